// File: rtl/apu_frame_counter.sv
// APU frame sequencer: counts CPU cycles, emits quarter/half-frame strobes,
// raises the 4-step frame IRQ and handles delayed $4017 counter resets.
// Ports: clk_in, rst_n_in (async, active-low); cpu_cycle_pulse_in;
//   d_in/wr_in ($4017 write); irq_ack_in ($4015 read ack);
//   eg_pulse_out (quarter), lc_pulse_out (half), frame_irq_out (level).
module apu_frame_counter #(
  parameter int unsigned STEP1    = 7457,
  parameter int unsigned STEP2    = 14913,
  parameter int unsigned STEP3    = 22371,
  parameter int unsigned STEP4    = 29829,
  parameter int unsigned STEP5    = 37281,
  parameter int unsigned WR_DELAY = 3
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cpu_cycle_pulse_in,
  input  logic [7:0] d_in,
  input  logic       wr_in,
  input  logic       irq_ack_in,
  output logic       eg_pulse_out,
  output logic       lc_pulse_out,
  output logic       frame_irq_out
);

  localparam logic [15:0] S1  = 16'(STEP1);
  localparam logic [15:0] S2  = 16'(STEP2);
  localparam logic [15:0] S3  = 16'(STEP3);
  localparam logic [15:0] S4  = 16'(STEP4);
  localparam logic [15:0] S5  = 16'(STEP5);
  localparam logic [1:0]  DLY = 2'(WR_DELAY - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  dly_q, dly_d;
  logic        mode_q, mode_d;
  logic        inh_q, inh_d;
  logic        irq_q, irq_d;
  logic        pend_q, pend_d;
  logic        eg_q, eg_d;
  logic        lc_q, lc_d;
  logic [15:0] last;
  logic [15:0] nxt;
  logic        set_irq;

  always_comb begin
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    mode_d  = mode_q;
    inh_d   = inh_q;
    irq_d   = irq_q;
    pend_d  = pend_q;
    eg_d    = 1'b0;
    lc_d    = 1'b0;
    set_irq = 1'b0;

    // A write lands before a coincident CPU pulse, so the
    // pulse below already sees the new mode and delay.
    if (wr_in) begin
      mode_d = d_in[7];
      inh_d  = d_in[6];
      pend_d = 1'b1;
      dly_d  = DLY;
    end

    // ">=" makes a 1->0 mode switch past STEP4 wrap at once.
    last = mode_d ? S5 : S4;
    nxt  = (cnt_q >= last) ? 16'd0 : cnt_q + 16'd1;

    if (cpu_cycle_pulse_in) begin
      if (pend_d && (dly_d == 2'd0)) begin
        cnt_d  = 16'd0;
        pend_d = 1'b0;
        eg_d   = mode_d;
        lc_d   = mode_d;
      end else begin
        if (pend_d) dly_d = dly_d - 2'd1;
        cnt_d = nxt;
        unique case (1'b1)
          (nxt == S1), (nxt == S3): begin
            eg_d = 1'b1;
          end
          (nxt == S2): begin
            eg_d = 1'b1;
            lc_d = 1'b1;
          end
          (nxt == S4 && !mode_d): begin
            eg_d    = 1'b1;
            lc_d    = 1'b1;
            set_irq = !inh_d;
          end
          (nxt == S5 && mode_d): begin
            eg_d = 1'b1;
            lc_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (irq_ack_in || (wr_in && d_in[6])) irq_d = 1'b0;
    if (set_irq) irq_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q  <= '0;
      dly_q  <= '0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
      eg_q   <= 1'b0;
      lc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dly_q  <= dly_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      irq_q  <= irq_d;
      pend_q <= pend_d;
      eg_q   <= eg_d;
      lc_q   <= lc_d;
    end
  end

  assign eg_pulse_out  = eg_q;
  assign lc_pulse_out  = lc_q;
  assign frame_irq_out = irq_q;

endmodule

// File: doc/apu_frame_counter.md
# apu_frame_counter

Frame sequencer for the APU. Counts CPU cycles and emits the quarter-frame (envelope) and half-frame (length counter) strobes consumed by the pulse, triangle and noise channels through their `eg_pulse_in` and `lc_pulse_in` ports. Raises the frame IRQ flag in 4-step mode. Decodes writes to $4017 (mode and IRQ inhibit) and accepts the $4015-read acknowledge from the register block.

## Interface
Parameters:
- `STEP1`, default 7457: counter value for step 1 (quarter).
- `STEP2`, default 14913: counter value for step 2 (quarter + half).
- `STEP3`, default 22371: counter value for step 3 (quarter).
- `STEP4`, default 29829: 4-step final step (quarter + half + IRQ) and last count.
- `STEP5`, default 37281: 5-step final step (quarter + half) and last count.
- `WR_DELAY`, default 3: CPU cycles from a $4017 write to the counter reset.

Ports:
- `clk_in` input 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n_in` input 1: asynchronous active-low reset.
- `cpu_cycle_pulse_in` input 1: 1-clk pulse on every CPU cycle.
- `d_in` input 8: write data for $4017. Bit 7 is mode (0 = 4-step, 1 = 5-step); bit 6 is IRQ inhibit.
- `wr_in` input 1: 1-clk write strobe for $4017.
- `irq_ack_in` input 1: 1-clk pulse on a $4015 read; clears the IRQ flag.
- `eg_pulse_out` output 1: 1-clk quarter-frame strobe.
- `lc_pulse_out` output 1: 1-clk half-frame strobe.
- `frame_irq_out` output 1: frame IRQ flag, level.

## Operation
Registered state:
- 16-bit `cnt`.
- `mode`.
- `inhibit`.
- `irq_flag`.
- Pending-reset flag plus a 2-bit delay counter `dly`.

Reset (`rst_n_in` low, asynchronous): all state is 0, and all outputs are 0 while reset is asserted. Operation resumes in 4-step mode with the counter at 0.

Counting:
- On a clk with `cpu_cycle_pulse_in`=1, `cnt` advances.
- The next value is 0 if `cnt` is the last count for the current mode (STEP4 for mode 0, STEP5 for mode 1). Otherwise it is `cnt`+1.
- Step events are decoded on the next value, i.e. the value being loaded.

Step events, by next value:
- STEP1 or STEP3: quarter.
- STEP2: quarter + half.
- STEP4 with mode 0: quarter + half, and set `irq_flag` if `inhibit`=0.
- STEP5 with mode 1: quarter + half.
- STEP4 with mode 1: no event.
- Quarter drives `eg_pulse_out`=1 for one clk; half drives `lc_pulse_out`=1 for one clk.

$4017 write (`wr_in`=1):
- `mode` and `inhibit` load from `d_in[7:6]` on the same edge.
- If `d_in[6]`=1, `irq_flag` clears on the same edge.
- The pending flag is set and `dly` is set to `WR_DELAY`-1.

Pending reset:
- Each `cpu_cycle_pulse_in` while pending decrements `dly`. The counter keeps counting in the new mode meanwhile.
- On the pulse where `dly`==0: load `cnt` to 0 and clear pending. This pulse replaces the normal advance, and no step event is decoded on it.
- If `mode`=1 at that moment, emit quarter + half on that pulse.

IRQ flag:
- `irq_flag` clears on `irq_ack_in`.
- `frame_irq_out` = `irq_flag`.

## Timing
- Strobes are registered and appear exactly 1 clk after the qualifying `cpu_cycle_pulse_in` edge.
- Strobes are never wider than 1 clk, and never repeat without another CPU pulse.
- Write with `cpu_cycle_pulse_in` in the same clk: the write counts as occurring before that pulse, so the pulse is the first decrement. The reset therefore lands on the WR_DELAY-th CPU pulse counted from and including that one.
- Second write while pending: `mode`/`inhibit` update and the delay restarts at `WR_DELAY`-1 (last write wins).
- Pending-reset expiry on the same pulse as a step match: the reset wins. The old step event is suppressed; only the mode-1 forced quarter + half is emitted.
- IRQ set and `irq_ack_in` in the same clk: set wins, so the flag stays 1.
- IRQ set and a write with `d_in[6]`=1 in the same clk: the flag ends 0, because inhibit takes effect immediately.
- Mode switch 1→0 while `cnt` > STEP4: the wrap happens at the next CPU pulse (next value 0), with no IRQ.
- Reset asserted mid-frame: the counter, the pending write and the flag are all discarded.
- `cnt` never exceeds STEP5. Width is 16 bits with no overflow path.

## Test plan
- Reset, then 29830 CPU pulses in mode 0:
  - `eg_pulse_out` at next-values 7457, 14913, 22371, 29829.
  - `lc_pulse_out` at 14913 and 29829.
  - `frame_irq_out` rises 1 clk after the pulse making `cnt`=29829.
  - `cnt` is 0 after the 29830th pulse.
- Write `d_in`=8'h80: on the 3rd CPU pulse counted from the write, `cnt`=0 and quarter + half fire together. A full 37282-pulse frame then gives strobes at 7457, 14913, 22371, 37281, with no IRQ.
- 4-step with IRQ flag set, then `irq_ack_in` pulse: flag is 0 the next clk. Assert the ack on the same clk as a set at STEP4: flag reads 1.
- Write 8'h40 while the flag is 1: flag is 0 the next clk. Run a full 4-step frame: flag stays 0 and the strobes are unchanged.
- Write 8'h80 at `cnt`=14910, then a second write 8'h00 one pulse later: the reset lands 3 pulses after the second write with no forced strobes. The STEP2 event at 14913 is suppressed if it coincides with the reset pulse.
- Assert `rst_n_in` low mid-delay at `cnt`=20000 with the IRQ flag set: all outputs are 0 immediately (asynchronously). After release, the first quarter strobe occurs at pulse 7457.
